seq_calc_acc: RTL and testbench

//  Registered, parametrised successor to the 4-bit combinational calculator.
//  - Same 3-bit opcode set, generalised to WIDTH-bit two's-complement operands.
//  - Adds valid/ready handshakes on input and output, selectable wrap or saturate arithmetic,
//    an accumulator operand source and a sticky overflow flag.
//  - Sits between an operand source (e.g. a register file or a UART command parser) and a

---
 rtl/seq_calc_acc_if.sv | 28 ++
 rtl/seq_calc_acc.sv | 133 +++++++++++++
 tb/tb_seq_calc_acc.sv | 198 +++++++++++++++++++
 3 files changed

// File: rtl/seq_calc_acc_if.sv
// Operand/result handshake bundle for seq_calc_acc.
// The calculator is the slave; the operand source and the result sink together form the master.
interface seq_calc_acc_if #(
   parameter int WIDTH = 4
);
   logic             in_valid;
   logic             in_ready;
   logic [2:0]       op;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             use_acc;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] result;
   logic             ovf;
   logic             ovf_sticky;
   logic             clr_ovf;

   modport master (
      output in_valid, op, a, b, use_acc, out_ready, clr_ovf,
      input  in_ready, out_valid, result, ovf, ovf_sticky
   );

   modport slave (
      input  in_valid, op, a, b, use_acc, out_ready, clr_ovf,
      output in_ready, out_valid, result, ovf, ovf_sticky
   );
endinterface

// File: rtl/seq_calc_acc.sv
// Registered WIDTH-bit calculator with an accumulator, wrap/saturate arithmetic and sticky overflow.
// Each operation runs IDLE -> EXEC -> DONE; a new operand set is accepted only in IDLE.
module seq_calc_acc #(
   parameter int WIDTH    = 4,
   parameter bit SATURATE = 1'b0
) (
   input  logic          clk,
   input  logic          rst_n,
   seq_calc_acc_if.slave bus
);
   localparam logic [WIDTH-1:0] MAXP = {1'b0, {(WIDTH-1){1'b1}}};
   localparam logic [WIDTH-1:0] MINN = {1'b1, {(WIDTH-1){1'b0}}};

   typedef enum logic [1:0] {IDLE, EXEC, DONE} stateT;

   stateT            stateReg, stateNext;
   logic [2:0]       opReg;
   logic [WIDTH-1:0] aReg, bReg, accReg, resultReg;
   logic             ovfReg, stickyReg;

   logic [WIDTH-1:0] addX, addY, sum, absIn, absNeg, calcResult;
   logic [WIDTH:0]   carry;
   logic             addCin, isAbs, calcOvf;

   // Route the latched operands to the shared adder or to the absolute-value path.
   always_comb begin
      addX   = '0;
      addY   = '0;
      addCin = 1'b0;
      absIn  = '0;
      isAbs  = 1'b0;
      unique case (opReg[2:1])
         2'b00: begin
            addX   = aReg;
            addY   = opReg[0] ? ~bReg : bReg;
            addCin = opReg[0];
         end
         2'b01: begin
            isAbs = 1'b1;
            absIn = bReg;
         end
         2'b10: begin
            addX   = bReg;
            addY   = opReg[0] ? ~aReg : aReg;
            addCin = opReg[0];
         end
         default: begin
            isAbs = 1'b1;
            absIn = aReg;
         end
      endcase
   end

   // Explicit ripple chain so the carry into and out of the sign bit are both visible.
   assign carry[0] = addCin;
   genvar gi;
   generate
      for (gi = 0; gi < WIDTH; gi++) begin : gRipple
         assign sum[gi]      = addX[gi] ^ addY[gi] ^ carry[gi];
         assign carry[gi+1]  = (addX[gi] & addY[gi]) | (carry[gi] & (addX[gi] ^ addY[gi]));
      end
   endgenerate

   assign absNeg = ~absIn + 1'b1;

   always_comb begin
      calcOvf    = 1'b0;
      calcResult = sum;
      if (isAbs) begin
         if (!absIn[WIDTH-1]) begin
            calcResult = absIn;
         end else if (absIn == MINN) begin
            calcOvf    = 1'b1;
            calcResult = SATURATE ? MAXP : MINN;
         end else begin
            calcResult = absNeg;
         end
      end else begin
         calcOvf = carry[WIDTH] ^ carry[WIDTH-1];
         // Both addends share the sign of addX when overflow occurs, so it gives the clamp direction.
         if (calcOvf && SATURATE) begin
            calcResult = addX[WIDTH-1] ? MINN : MAXP;
         end
      end
   end

   always_comb begin
      stateNext = stateReg;
      unique case (stateReg)
         IDLE:    if (bus.in_valid) stateNext = EXEC;
         EXEC:    stateNext = DONE;
         DONE:    if (bus.out_ready) stateNext = IDLE;
         default: stateNext = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         stateReg  <= IDLE;
         opReg     <= '0;
         aReg      <= '0;
         bReg      <= '0;
         accReg    <= '0;
         resultReg <= '0;
         ovfReg    <= 1'b0;
         stickyReg <= 1'b0;
      end else begin
         stateReg <= stateNext;
         if (stateReg == IDLE && bus.in_valid) begin
            opReg <= bus.op;
            aReg  <= bus.use_acc ? accReg : bus.a;
            bReg  <= bus.b;
         end
         if (stateReg == EXEC) begin
            resultReg <= calcResult;
            ovfReg    <= calcOvf;
            accReg    <= calcResult;
         end
         // A fresh overflow outranks a simultaneous clear request.
         if (stateReg == EXEC && calcOvf) begin
            stickyReg <= 1'b1;
         end else if (bus.clr_ovf) begin
            stickyReg <= 1'b0;
         end
      end
   end

   assign bus.in_ready   = (stateReg == IDLE);
   assign bus.out_valid  = (stateReg == DONE);
   assign bus.result     = resultReg;
   assign bus.ovf        = ovfReg;
   assign bus.ovf_sticky = stickyReg;
endmodule

// File: tb/tb_seq_calc_acc.sv
// Drives a wrapping and a saturating seq_calc_acc in lockstep and compares both against
// an integer-arithmetic reference of the calculator rules.
module tb_seq_calc_acc;
   localparam int W    = 4;
   localparam int FULL = 2 ** W;
   localparam int HALF = 2 ** (W - 1);
   localparam int MAXP = HALF - 1;
   localparam int MINN = -HALF;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   seq_calc_acc_if #(.WIDTH(W)) busW ();
   seq_calc_acc_if #(.WIDTH(W)) busS ();

   seq_calc_acc #(.WIDTH(W), .SATURATE(1'b0)) dutW (.clk(clk), .rst_n(rst_n), .bus(busW.slave));
   seq_calc_acc #(.WIDTH(W), .SATURATE(1'b1)) dutS (.clk(clk), .rst_n(rst_n), .bus(busS.slave));

   int checks = 0;
   int failures = 0;
   int accW = 0, accS = 0;
   bit stickyW = 1'b0, stickyS = 1'b0;

   task automatic checkVal(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         failures++;
         $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic int toS(input int v);
      return (v >= HALF) ? v - FULL : v;
   endfunction

   // Reference: exact signed math, then detect range escape and wrap or clamp.
   task automatic refCalc(input bit sat, input int opc, input int av, input int bv,
                          output int res, output bit ov);
      int x, y, r;
      x = toS(av);
      y = toS(bv);
      case (opc)
         0:       r = x + y;
         1:       r = x - y;
         2, 3:    r = (y < 0) ? -y : y;
         4:       r = y + x;
         5:       r = y - x;
         default: r = (x < 0) ? -x : x;
      endcase
      ov = (r > MAXP) || (r < MINN);
      if (ov && sat) r = (r > MAXP) ? MAXP : MINN;
      res = ((r % FULL) + FULL) % FULL;
   endtask

   task automatic driveIn(input bit v, input int opc, input int av, input int bv, input bit ua);
      logic [31:0] o, x, y;
      o = opc;
      x = av;
      y = bv;
      busW.in_valid = v;  busS.in_valid = v;
      busW.op = o[2:0];   busS.op = o[2:0];
      busW.a = x[W-1:0];  busS.a = x[W-1:0];
      busW.b = y[W-1:0];  busS.b = y[W-1:0];
      busW.use_acc = ua;  busS.use_acc = ua;
   endtask

   task automatic driveJunk(input bit v);
      driveIn(v, $urandom_range(7), $urandom_range(FULL - 1), $urandom_range(FULL - 1),
              1'($urandom_range(1)));
   endtask

   // Starts and ends at a falling edge with both DUTs in IDLE.
   task automatic doOp(input int opc, input int av, input int bv, input bit ua,
                       input int stall, input bit clr);
      int expW, expS, aW, aS;
      bit ovW, ovS;
      logic [31:0] ew, es;
      checkVal("idle_ready", {busW.in_ready, busS.in_ready, busW.out_valid, busS.out_valid}, 4'b1100);
      driveIn(1'b1, opc, av, bv, ua);
      @(negedge clk);
      driveJunk(1'b0);
      busW.clr_ovf = clr;
      busS.clr_ovf = clr;
      checkVal("exec_hs", {busW.in_ready, busW.out_valid, busS.in_ready, busS.out_valid}, 4'b0000);
      aW = ua ? accW : av;
      aS = ua ? accS : av;
      refCalc(1'b0, opc, aW, bv, expW, ovW);
      refCalc(1'b1, opc, aS, bv, expS, ovS);
      accW = expW;
      accS = expS;
      stickyW = ovW | (stickyW & !clr);
      stickyS = ovS | (stickyS & !clr);
      ew = expW;
      es = expS;
      @(negedge clk);
      busW.clr_ovf = 1'b0;
      busS.clr_ovf = 1'b0;
      checkVal("done_hs", {busW.out_valid, busW.in_ready, busS.out_valid, busS.in_ready}, 4'b1010);
      checkVal("resultW", busW.result, ew[W-1:0]);
      checkVal("resultS", busS.result, es[W-1:0]);
      checkVal("ovfW", busW.ovf, ovW);
      checkVal("ovfS", busS.ovf, ovS);
      checkVal("stickyW", busW.ovf_sticky, stickyW);
      checkVal("stickyS", busS.ovf_sticky, stickyS);
      $display("op=%0d a=%0h b=%0h use_acc=%0d stall=%0d clr=%0d -> wrap %0h/%0d sat %0h/%0d",
               opc, av, bv, ua, stall, clr, busW.result, busW.ovf, busS.result, busS.ovf);
      for (int i = 0; i < stall; i++) begin
         driveJunk(1'b1);
         @(negedge clk);
         checkVal("stallW", {busW.out_valid, busW.in_ready, busW.ovf, busW.result}, {1'b1, 1'b0, ovW, ew[W-1:0]});
         checkVal("stallS", {busS.out_valid, busS.in_ready, busS.ovf, busS.result}, {1'b1, 1'b0, ovS, es[W-1:0]});
      end
      driveJunk(1'b0);
      busW.out_ready = 1'b1;
      busS.out_ready = 1'b1;
      @(negedge clk);
      busW.out_ready = 1'b0;
      busS.out_ready = 1'b0;
      checkVal("retired", {busW.out_valid, busW.in_ready, busS.out_valid, busS.in_ready}, 4'b0101);
   endtask

   task automatic clearSticky();
      busW.clr_ovf = 1'b1;
      busS.clr_ovf = 1'b1;
      @(negedge clk);
      busW.clr_ovf = 1'b0;
      busS.clr_ovf = 1'b0;
      stickyW = 1'b0;
      stickyS = 1'b0;
      checkVal("clr_sticky", {busW.ovf_sticky, busS.ovf_sticky}, {stickyW, stickyS});
      $display("clr_ovf -> sticky wrap=%0d sat=%0d", busW.ovf_sticky, busS.ovf_sticky);
   endtask

   task automatic checkResetState(input string tag);
      checkVal(tag, {busW.in_ready, busW.out_valid, busW.ovf, busW.ovf_sticky, busW.result},
                    {1'b1, 1'b0, 1'b0, 1'b0, 4'h0});
      checkVal(tag, {busS.in_ready, busS.out_valid, busS.ovf, busS.ovf_sticky, busS.result},
                    {1'b1, 1'b0, 1'b0, 1'b0, 4'h0});
   endtask

   task automatic resetMidExec();
      driveIn(1'b1, 0, 7, 1, 1'b0);
      @(negedge clk);
      driveJunk(1'b0);
      rst_n = 1'b0;
      #1;
      checkResetState("reset_mid_exec");
      accW = 0;
      accS = 0;
      stickyW = 1'b0;
      stickyS = 1'b0;
      $display("reset asserted during EXEC");
      @(negedge clk);
      rst_n = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         checkVal("no_valid_after_reset", {busW.out_valid, busS.out_valid, busW.in_ready, busS.in_ready}, 4'b0011);
      end
   endtask

   initial begin
      driveIn(1'b0, 0, 0, 0, 1'b0);
      busW.out_ready = 1'b0; busS.out_ready = 1'b0;
      busW.clr_ovf = 1'b0;   busS.clr_ovf = 1'b0;
      rst_n = 1'b0;
      repeat (2) @(negedge clk);
      checkResetState("reset_state");
      rst_n = 1'b1;
      @(negedge clk);

      doOp(0, 4'b0111, 4'b0001, 1'b0, 0, 1'b0);   // 7+1 overflows
      clearSticky();
      doOp(5, 4'b0111, 4'b1000, 1'b0, 0, 1'b0);   // -8-7
      doOp(1, 4'b0011, 4'b0101, 1'b0, 0, 1'b0);   // 3-5
      doOp(6, 4'b1000, 4'b0000, 1'b0, 0, 1'b0);   // |MINN|
      doOp(7, 4'b1000, 4'b0101, 1'b0, 0, 1'b0);
      doOp(2, 4'b0110, 4'b1101, 1'b0, 0, 1'b0);   // |-3|
      doOp(3, 4'b0000, 4'b1000, 1'b0, 0, 1'b0);
      doOp(4, 4'b0100, 4'b0101, 1'b0, 5, 1'b0);   // stalled sink, back-to-back after
      doOp(0, 4'b0010, 4'b0001, 1'b0, 0, 1'b0);   // accumulate chain
      doOp(0, 4'b1111, 4'b0010, 1'b1, 0, 1'b0);
      doOp(6, 4'b1001, 4'b0000, 1'b1, 0, 1'b0);
      resetMidExec();
      doOp(6, 4'b0101, 4'b0000, 1'b1, 0, 1'b0);   // acc cleared by reset
      doOp(0, 4'b0110, 4'b0011, 1'b0, 1, 1'b1);   // clear coincides with overflow
      doOp(0, 4'b0001, 4'b0001, 1'b0, 0, 1'b1);   // clear with no overflow

      for (int n = 0; n < 80; n++) begin
         doOp($urandom_range(7), $urandom_range(FULL - 1), $urandom_range(FULL - 1),
              ($urandom_range(3) == 0), $urandom_range(3), ($urandom_range(6) == 0));
         if (n % 10 == 9) clearSticky();
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
